alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, together with the two operands, and produces a registered result and zero flag. Operands and opcode are accepted through a valid/ready handshake. Logic and arithmetic ops complete in one cycle. Shift ops run iteratively, one bit per cycle. Sits between the ALU controller/register-file read stage and the writeback/branch logic.

Parameters:
WIDTH, 32, operand and result width in bits (power of 2, >= 8)
SHAMT_W, 5, shift-amount width; equals log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active low
in_valid  input  1  operation, a and b are valid
in_ready  output  1  unit can accept an operation
operation  input  4  ALU operation code from the ALU controller
a  input  WIDTH  operand A (rs1)
b  input  WIDTH  operand B (rs2/imm); b[SHAMT_W-1:0] is the shift amount
out_valid  output  1  result and zero are valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  registered ALU result
zero  output  1  high when result == 0

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 1100 XOR; 0010 ADD; 0110 SUB (a-b).
  - 0111 SLT: signed a<b gives result 1, else 0.
  - 1000 SLL; 1001 SRL; 1010 SRA (iterative).
  - Any other code: result 0, zero 1, latency 1.
- Add/sub wrap modulo 2^WIDTH. SLT compares two's-complement values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, latch operands.
  - Non-shift op: compute result and go to DONE next cycle (out_valid high 1 cycle after accept).
  - Shift op: load work register=a and counter=b[SHAMT_W-1:0].
    - Counter 0: go straight to DONE with result=a.
    - Otherwise go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: shift work register by 1 and decrement counter.
  - SLL fills 0. SRL fills 0. SRA fills with bit WIDTH-1.
  - When counter reaches 0 after the shift, go to DONE.
  - Shift by n: out_valid rises n+1 cycles after accept.
- DONE:
  - out_valid=1, in_ready=0. result and zero held stable.
  - On out_ready=1, go to IDLE. The next op can be accepted the following cycle, so minimum throughput is 1 op per 2 cycles.
  - out_ready=0 stalls indefinitely with no change to outputs.
- Upper operand bits b[WIDTH-1:SHAMT_W] are ignored for shifts.
- Inputs are ignored while in_ready=0. in_valid in SHIFT/DONE has no effect.
- zero is registered with result (zero = ~|result), never combinational from inputs.
- Reset (rst_n=0 at clk edge), from any state including mid-shift:
  - FSM goes to IDLE; in-flight op is discarded.
  - in_ready=1 is asserted in the cycle after reset is released.
  - out_valid=0, result=0, zero=1, counter=0.
- In_ready during reset: low while rst_n=0.

Optional Feature:
ALU_OVERFLOW_EN
- Defined: adds output port overflow (1 bit), registered with result.
  - ADD: set on signed overflow, i.e. a and b have the same sign and result sign differs.
  - SUB: set when a and b have different signs and result sign differs from a.
  - 0 for all other ops. Reset value 0. Held stable in DONE.
- Undefined: port and its logic are absent; all other behaviour identical.

Test Plan:
- Reset then single ADD: a=5, b=7, op=0010 accepted -> next cycle out_valid=1, result=12, zero=0. out_ready=1 -> IDLE, in_ready=1 following cycle.
- SUB to zero and backpressure: a=0x1234, b=0x1234, op=0110 -> result=0, zero=1. Hold out_ready=0 for 5 cycles -> out_valid, result and zero unchanged, in_ready=0, new in_valid ignored.
- SLT signedness: a=0xFFFFFFFF, b=1, op=0111 -> result=1. Swap operands -> result=0. Then op=0101 (undefined) -> result=0, zero=1.
- Iterative shifts:
  - SRA a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000.
  - SRL same operands -> 0x08000000.
  - SLL a=1, b=0x25 (shamt 5) -> result=0x20.
  - SLL with b=0 -> result=a, latency 1.
- Reset mid-shift: SLL a=1, b=31; assert rst_n=0 after 10 cycles -> next edge out_valid=0, result=0, zero=1. After release in_ready=1; a following AND 0xF0F0&0xFF00 -> 0xF000.
- With ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1. SUB 0x80000000-1 -> overflow=1. ADD 2+3 -> overflow=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake on both sides.
// Logic/arithmetic ops finish in one cycle; SLL/SRL/SRA shift one bit per
// cycle. Optional macro ALU_OVERFLOW_EN adds a registered signed-overflow
// output for ADD/SUB.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   result_p1;
    logic               zero_p1;
    logic [SHAMT_W-1:0] cnt_p1;
    logic [1:0]         kind_p1;
    logic [WIDTH-1:0]   alu_p0;
    logic [WIDTH-1:0]   shifted_p1;
    logic [SHAMT_W-1:0] shamt_p0;
`ifdef ALU_OVERFLOW_EN
    logic               ovf_p1;
`endif

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Single-cycle ops; undefined codes yield 0.
    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        sx = x;
        sy = y;
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLT:  return (sx < sy) ? WIDTH'(1) : '0;
            default: return '0;
        endcase
    endfunction

    // One-bit shift step; kind is the low two opcode bits (00 SLL, 01 SRL, 10 SRA).
    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                   input logic [WIDTH-1:0] v);
        case (kind)
            2'b00:   return {v[WIDTH-2:0], 1'b0};
            2'b01:   return {1'b0, v[WIDTH-1:1]};
            2'b10:   return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return v;
        endcase
    endfunction

`ifdef ALU_OVERFLOW_EN
    // Signed overflow of ADD/SUB judged from operand and result sign bits.
    function automatic logic add_sub_ovf(input logic [3:0] op,
                                         input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y,
                                         input logic [WIDTH-1:0] r);
        case (op)
            OP_ADD:  return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            OP_SUB:  return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            default: return 1'b0;
        endcase
    endfunction
`endif

    assign alu_p0     = alu_single(operation, a, b);
    assign shamt_p0   = b[SHAMT_W-1:0];
    assign shifted_p1 = shift_one(kind_p1, result_p1);

    // ---- stage p1: registered outputs ----
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_p1;
    assign zero      = zero_p1;
`ifdef ALU_OVERFLOW_EN
    assign overflow  = ovf_p1;
`endif

    // Control FSM plus the result/work register it sequences.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            result_p1 <= '0;
            zero_p1   <= 1'b1;
            cnt_p1    <= '0;
            kind_p1   <= 2'b00;
`ifdef ALU_OVERFLOW_EN
            ovf_p1    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift(operation)) begin
                            // result_p1 doubles as the shift work register
                            result_p1 <= a;
                            zero_p1   <= ~|a;
                            kind_p1   <= operation[1:0];
                            cnt_p1    <= shamt_p0;
                            state     <= (shamt_p0 == '0) ? DONE : SHIFT;
`ifdef ALU_OVERFLOW_EN
                            ovf_p1    <= 1'b0;
`endif
                        end else begin
                            result_p1 <= alu_p0;
                            zero_p1   <= ~|alu_p0;
                            state     <= DONE;
`ifdef ALU_OVERFLOW_EN
                            ovf_p1    <= add_sub_ovf(operation, a, b, alu_p0);
`endif
                        end
                    end
                end
                SHIFT: begin
                    result_p1 <= shifted_p1;
                    zero_p1   <= ~|shifted_p1;
                    cnt_p1    <= cnt_p1 - SHAMT_W'(1);
                    if (cnt_p1 == SHAMT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized bench for alu_exec_unit with a
// behavioural reference model. Define ALU_OVERFLOW_EN to cover the overflow port.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
`ifdef ALU_OVERFLOW_EN
    logic         overflow;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic straight from the opcode table.
    function automatic logic [W-1:0] model_result(input logic [3:0] op,
                                                  input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
        int sh;
        sh = int'(y % W);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b1100: return x ^ y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000: return x << sh;
            4'b1001: return x >> sh;
            4'b1010: return $signed(x) >>> sh;
            default: return '0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [W-1:0] y);
        if (op == 4'b1000 || op == 4'b1001 || op == 4'b1010)
            return int'(y % W) + 1;
        return 1;
    endfunction

    // Overflow when the exact signed sum/difference falls outside the W-bit range.
    function automatic logic model_ovf(input logic [3:0] op,
                                       input logic [W-1:0] x,
                                       input logic [W-1:0] y);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'b0010)      s = sx + sy;
        else if (op == 4'b0110) s = sx - sy;
        else                    return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int stall);
        logic [W-1:0] exp;
        int           n;
        exp = model_result(op, x, y);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        operation = op;
        a         = x;
        b         = y;
        @(negedge clk);
        in_valid  = 1'b0;
        operation = 4'($urandom);
        a         = $urandom;
        b         = $urandom;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("latency op=%h", op), n, model_latency(op, y));
        check($sformatf("result op=%h a=%h b=%h", op, x, y), result, exp);
        check("zero", zero, exp == '0);
`ifdef ALU_OVERFLOW_EN
        check($sformatf("overflow op=%h", op), overflow, model_ovf(op, x, y));
`endif
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid  = 1'b1;
            operation = 4'($urandom);
            a         = $urandom;
            b         = $urandom;
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_result", result, exp);
            check("stall_zero", zero, exp == '0);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clr", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    logic [3:0] op_tab [12];
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    initial begin
        op_tab = '{4'h0, 4'h1, 4'hC, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h3, 4'h5, 4'hF};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Directed cases
        run_op(4'b0010, 32'd5, 32'd7, 0);
        run_op(4'b0110, 32'h1234, 32'h1234, 5);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b0111, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(4'b0101, 32'hDEAD_BEEF, 32'h1, 0);
        run_op(4'b1010, 32'h8000_0000, 32'd4, 1);
        run_op(4'b1001, 32'h8000_0000, 32'd4, 0);
        run_op(4'b1000, 32'd1, 32'h25, 0);
        run_op(4'b1000, 32'hA5A5_0001, 32'h0, 0);
        run_op(4'b1000, 32'h8000_0001, 32'd1, 0);
        run_op(4'b1010, 32'h8000_0000, 32'd31, 0);
`ifdef ALU_OVERFLOW_EN
        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(4'b0110, 32'h8000_0000, 32'd1, 0);
        run_op(4'b0010, 32'd2, 32'd3, 0);
`endif

        // Reset in the middle of a long shift
        in_valid  = 1'b1;
        operation = 4'b1000;
        a         = 32'd1;
        b         = 32'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midshift_no_valid", out_valid, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_zero", zero, 1);
        check("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_in_ready", in_ready, 1);
        run_op(4'b0000, 32'hF0F0, 32'hFF00, 0);

        // Randomized operations against the model
        for (int k = 0; k < 60; k++) begin
            rop = op_tab[$urandom_range(0, 11)];
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 4))
                0: ra = 32'h7FFF_FFFF;
                1: ra = 32'h8000_0000;
                2: rb = ra;
                default: ;
            endcase
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
